// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel phase-locked PWM with prescaler, edge/center counting and double-buffered duty
module pwm_multi #(
   parameter int CH = 4,
   parameter int CW = 8,
   parameter int PW = 8
) (
   input  logic                   clk,
   input  logic                   sys_rst_n,
   input  logic                   enable,
   input  logic                   mode,
   input  logic [CW-1:0]          period,
   input  logic [PW-1:0]          prescale,
   input  logic                   wr_en,
   input  logic [$clog2(CH)-1:0]  wr_ch,
   input  logic [CW-1:0]          wr_duty,
   output logic [CH-1:0]          out,
   output logic                   period_end,
   output logic [CW-1:0]          cnt
);

   localparam int CHW = $clog2(CH);

   typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

   logic [PW-1:0]          pre_q, pre_d;
   logic [PW-1:0]          pre_a_q, pre_a_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [CW-1:0]          p_a_q, p_a_d;
   dir_t                   dir_q, dir_d;
   logic                   mode_a_q, mode_a_d;
   logic [CH-1:0][CW-1:0]  duty_a_q, duty_a_d;
   logic [CH-1:0][CW-1:0]  duty_s_q, duty_s_d;
   logic [CH-1:0]          out_q, out_d;
   logic                   period_end_q, period_end_d;
   logic                   tick;
   logic                   boundary;
   logic                   load_active;

   // Prescaler and shared counter: next count, direction and period boundary
   always_comb begin
      tick     = (pre_q == pre_a_q);
      boundary = 1'b0;
      pre_d    = pre_q;
      cnt_d    = cnt_q;
      dir_d    = dir_q;
      if (!enable) begin
         pre_d = '0;
         cnt_d = '0;
         dir_d = DIR_UP;
      end else if (tick) begin
         pre_d = '0;
         if (p_a_q == '0) begin
            // Degenerate period: counter parked at 0, every tick closes a period
            cnt_d    = '0;
            dir_d    = DIR_UP;
            boundary = 1'b1;
         end else if (!mode_a_q) begin
            dir_d = DIR_UP;
            if (cnt_q >= p_a_q) begin
               cnt_d    = '0;
               boundary = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end else if (dir_q == DIR_UP) begin
            if (cnt_q >= p_a_q) begin
               // Turn at the top; with P=1 the turn lands straight on 0
               if (p_a_q == CW'(1)) begin
                  cnt_d    = '0;
                  dir_d    = DIR_UP;
                  boundary = 1'b1;
               end else begin
                  cnt_d = p_a_q - 1'b1;
                  dir_d = DIR_DOWN;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end else begin
            if (cnt_q <= CW'(1)) begin
               cnt_d    = '0;
               dir_d    = DIR_UP;
               boundary = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
      end else begin
         pre_d = pre_q + 1'b1;
      end
   end

   // Active register reload at boundaries (or continuously while disabled) and shadow writes
   always_comb begin
      load_active = !enable || boundary;
      p_a_d       = p_a_q;
      mode_a_d    = mode_a_q;
      pre_a_d     = pre_a_q;
      duty_a_d    = duty_a_q;
      duty_s_d    = duty_s_q;
      if (load_active) begin
         p_a_d    = period;
         mode_a_d = mode;
         pre_a_d  = prescale;
         duty_a_d = duty_s_q;
      end
      for (int i = 0; i < CH; i++) begin
         if (wr_en && (wr_ch == CHW'(i))) begin
            duty_s_d[i] = wr_duty;
         end
      end
   end

   // Per-channel compare against the shared counter and boundary pulse
   always_comb begin
      out_d        = '0;
      period_end_d = boundary;
      for (int i = 0; i < CH; i++) begin
         out_d[i] = enable && (cnt_q < duty_a_q[i]);
      end
   end

   // State registers
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         pre_q        <= '0;
         pre_a_q      <= '0;
         cnt_q        <= '0;
         p_a_q        <= '0;
         dir_q        <= DIR_UP;
         mode_a_q     <= 1'b0;
         duty_a_q     <= '0;
         duty_s_q     <= '0;
         out_q        <= '0;
         period_end_q <= 1'b0;
      end else begin
         pre_q        <= pre_d;
         pre_a_q      <= pre_a_d;
         cnt_q        <= cnt_d;
         p_a_q        <= p_a_d;
         dir_q        <= dir_d;
         mode_a_q     <= mode_a_d;
         duty_a_q     <= duty_a_d;
         duty_s_q     <= duty_s_d;
         out_q        <= out_d;
         period_end_q <= period_end_d;
      end
   end

   assign out        = out_q;
   assign period_end = period_end_q;
   assign cnt        = cnt_q;

endmodule

// File: tb/tb_pwm_multi.sv
// tb/tb_pwm_multi.sv - scoreboard bench for pwm_multi against a period-phase reference model
module tb_pwm_multi;

   localparam int CH = 4;
   localparam int CW = 8;
   localparam int PW = 8;

   logic            clk = 1'b0;
   logic            sys_rst_n;
   logic            enable;
   logic            mode;
   logic [CW-1:0]   period;
   logic [PW-1:0]   prescale;
   logic            wr_en;
   logic [1:0]      wr_ch;
   logic [CW-1:0]   wr_duty;
   logic [CH-1:0]   out;
   logic            period_end;
   logic [CW-1:0]   cnt;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [CH-1:0] out;
      logic          pe;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t sb_q[$];

   // Reference model: position t within the current period plus a clock divider
   int m_sub, m_t, m_p, m_mode, m_pre;
   int m_duty_a[CH];
   int m_duty_s[CH];

   int win_hi[CH];
   int win_pe;

   pwm_multi #(.CH(CH), .CW(CW), .PW(PW)) dut (
      .clk        (clk),
      .sys_rst_n  (sys_rst_n),
      .enable     (enable),
      .mode       (mode),
      .period     (period),
      .prescale   (prescale),
      .wr_en      (wr_en),
      .wr_ch      (wr_ch),
      .wr_duty    (wr_duty),
      .out        (out),
      .period_end (period_end),
      .cnt        (cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int m_len();
      if (m_p == 0) return 1;
      return (m_mode != 0) ? 2 * m_p : m_p + 1;
   endfunction

   function automatic int m_cnt();
      if (m_mode != 0 && m_t > m_p) return 2 * m_p - m_t;
      return m_t;
   endfunction

   task automatic m_reset();
      m_sub = 0; m_t = 0; m_p = 0; m_mode = 0; m_pre = 0;
      for (int i = 0; i < CH; i++) begin
         m_duty_a[i] = 0;
         m_duty_s[i] = 0;
      end
   endtask

   // Model step on every clock edge; pushes the outputs expected after that edge
   always @(posedge clk) begin : model
      exp_t e;
      int   c;
      bit   bnd;
      e = '0;
      if (!sys_rst_n) begin
         m_reset();
      end else begin
         c = m_cnt();
         for (int i = 0; i < CH; i++) e.out[i] = enable && (c < m_duty_a[i]);
         bnd = 1'b0;
         if (!enable) begin
            m_sub = 0;
            m_t   = 0;
         end else if (m_sub == m_pre) begin
            m_sub = 0;
            if (m_t + 1 >= m_len()) begin
               m_t = 0;
               bnd = 1'b1;
            end else begin
               m_t++;
            end
         end else begin
            m_sub++;
         end
         if (!enable || bnd) begin
            m_p    = int'(period);
            m_mode = int'(mode);
            m_pre  = int'(prescale);
            for (int i = 0; i < CH; i++) m_duty_a[i] = m_duty_s[i];
         end
         if (wr_en && int'(wr_ch) < CH) m_duty_s[wr_ch] = int'(wr_duty);
         e.pe  = bnd;
         e.cnt = CW'(m_cnt());
      end
      sb_q.push_back(e);
   end

   // Monitor: compares DUT outputs to the oldest expectation on the falling edge
   always @(negedge clk) begin : monitor
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         if (!sys_rst_n) e = '0;
         chk("sb_out", int'(out), int'(e.out));
         chk("sb_period_end", int'(period_end), int'(e.pe));
         chk("sb_cnt", int'(cnt), int'(e.cnt));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int ch, input int d);
      wr_en   = 1'b1;
      wr_ch   = 2'(ch);
      wr_duty = CW'(d);
      step();
      wr_en   = 1'b0;
   endtask

   task automatic wait_cnt(input int v);
      int n;
      n = 0;
      while (int'(cnt) != v && n < 200) begin
         step();
         n++;
      end
      if (int'(cnt) != v) begin
         checks++;
         failures++;
         $display("FAIL wait_cnt_timeout actual=%0d expected=%0d", cnt, v);
      end
   endtask

   task automatic count_window(input int n);
      for (int i = 0; i < CH; i++) win_hi[i] = 0;
      win_pe = 0;
      repeat (n) begin
         @(negedge clk);
         for (int i = 0; i < CH; i++) if (out[i]) win_hi[i]++;
         if (period_end) win_pe++;
      end
      step();
   endtask

   // Directed scenarios followed by randomized traffic
   initial begin
      sys_rst_n = 1'b0;
      enable    = 1'b0;
      mode      = 1'b0;
      period    = '0;
      prescale  = '0;
      wr_en     = 1'b0;
      wr_ch     = '0;
      wr_duty   = '0;
      #2;
      chk("rst_out", int'(out), 0);
      chk("rst_period_end", int'(period_end), 0);
      chk("rst_cnt", int'(cnt), 0);
      step();
      sys_rst_n = 1'b1;

      // Edge mode, period 9, duty limits on the four channels
      enable = 1'b1;
      period = 8'd9;
      wr(0, 3);
      wr(1, 0);
      wr(2, 10);
      wr(3, 9);
      repeat (25) step();
      count_window(10);
      chk("edge_d3_hi", win_hi[0], 3);
      chk("edge_d0_hi", win_hi[1], 0);
      chk("edge_d10_hi", win_hi[2], 10);
      chk("edge_d9_hi", win_hi[3], 9);
      chk("edge_pe_per10", win_pe, 1);

      // Double buffering: mid-period write, then a write on the boundary cycle
      wait_cnt(4);
      wr(1, 7);
      wait_cnt(0);
      count_window(10);
      chk("dbuf_mid_hi", win_hi[1], 7);
      wait_cnt(9);
      wr(1, 2);
      wait_cnt(1);
      count_window(10);
      chk("dbuf_bnd_deferred_hi", win_hi[1], 7);
      wait_cnt(1);
      count_window(10);
      chk("dbuf_bnd_applied_hi", win_hi[1], 2);

      // Center mode, period 4, D=2
      mode   = 1'b1;
      period = 8'd4;
      wr(0, 2);
      repeat (40) step();
      count_window(8);
      chk("ctr_d2_hi", win_hi[0], 3);
      chk("ctr_d10_hi", win_hi[2], 8);
      chk("ctr_pe_per8", win_pe, 1);

      // Prescale 2, edge, period 3; then a mid-period period change
      mode     = 1'b0;
      prescale = 8'd2;
      period   = 8'd3;
      repeat (50) step();
      count_window(12);
      chk("pre_pe_per12", win_pe, 1);
      chk("pre_d2_hi", win_hi[0], 6);
      wait_cnt(1);
      period = 8'd1;
      repeat (30) step();
      count_window(6);
      chk("pre_p1_pe_per6", win_pe, 1);
      chk("pre_p1_d2_hi", win_hi[0], 6);

      // Asynchronous reset in the middle of a period
      prescale = 8'd0;
      period   = 8'd9;
      repeat (30) step();
      wait_cnt(5);
      #2;
      sys_rst_n = 1'b0;
      #1;
      chk("midrst_out", int'(out), 0);
      chk("midrst_cnt", int'(cnt), 0);
      chk("midrst_period_end", int'(period_end), 0);
      step();
      sys_rst_n = 1'b1;
      wr(0, 3);
      wr(1, 5);
      repeat (20) step();

      // Enable low for five clocks
      enable = 1'b0;
      repeat (5) begin
         step();
         chk("dis_out", int'(out), 0);
         chk("dis_cnt", int'(cnt), 0);
      end
      enable = 1'b1;
      repeat (20) step();

      // Randomized traffic
      repeat (3000) begin
         if ($urandom_range(0, 7) == 0) begin
            wr_en   = 1'b1;
            wr_ch   = 2'($urandom_range(0, 3));
            wr_duty = CW'($urandom_range(0, 14));
         end else begin
            wr_en = 1'b0;
         end
         if ($urandom_range(0, 39) == 0) period = CW'($urandom_range(0, 12));
         if ($urandom_range(0, 39) == 0) prescale = PW'($urandom_range(0, 3));
         if ($urandom_range(0, 39) == 0) mode = ~mode;
         if (enable) begin
            if ($urandom_range(0, 99) == 0) enable = 1'b0;
         end else begin
            if ($urandom_range(0, 3) == 0) enable = 1'b1;
         end
         sys_rst_n = ($urandom_range(0, 499) != 0);
         step();
      end
      wr_en     = 1'b0;
      sys_rst_n = 1'b1;
      repeat (5) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
